// File: rtl/outport_uart_tx_if.sv
// Write-side snoop of the CPU output port: the load strobe and the datapath bus
// that the UART transmitter captures bytes from.
interface outport_uart_tx_if;
    logic        Out_Portin;
    logic [31:0] Busout;

    modport master (output Out_Portin, output Busout);
    modport slave  (input  Out_Portin, input  Busout);
endinterface

// File: rtl/outport_uart_tx.sv
// Queues bytes written to the CPU output port and shifts each one out as an
// 8N1 UART frame; writes to a full queue are dropped and flagged, never stalled.
//
// Handshake: there is no back-pressure. A byte is accepted on every rising edge
// where bus.Out_Portin=1 and fifo_full=0 (registered value); otherwise it is
// dropped and overflow is set until Reset.
module outport_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             Reset,
    outport_uart_tx_if.slave bus,
    output logic             tx,
    output logic             busy,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_next;

    // Only the low byte of the bus is ever transmitted.
    logic unused_busout_hi;
    assign unused_busout_hi = ^bus.Busout[31:8];

    // Fullness and emptiness are judged on the registered flags, so a push
    // coinciding with the pop of a full queue is still refused.
    always_comb begin
        push       = bus.Out_Portin && !fifo_full;
        pop        = (state == S_IDLE) && !fifo_empty;
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.Busout[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (bus.Out_Portin && fifo_full) begin
                overflow <= 1'b1;
            end
            fifo_count <= count_next;
            fifo_empty <= (count_next == '0);
            fifo_full  <= (count_next == CNT_FULL);
        end
    end

    // tx and busy are updated on the same edge as the state they belong to,
    // so the line reflects the new state with no extra cycle of latency.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    baud <= '0;
                    if (!fifo_empty) begin
                        shift <= mem[rd_ptr];
                        state <= S_START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    baud  <= '0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx: frame waveform, queue ordering, overflow,
// push/pop collision, mid-frame reset and pointer wrap.
module tb_outport_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          Reset;
    logic          tx;
    logic          busy;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    outport_uart_tx_if bus ();

    outport_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .bus       (bus),
        .tx        (tx),
        .busy      (busy),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] word);
        bus.Out_Portin = 1'b1;
        bus.Busout     = word;
    endtask

    // Ideal line level at cycle i of a frame (i=0 is the first start-bit cycle).
    function automatic logic exp_tx(input logic [7:0] b, input int i);
        if (i < CPB) return 1'b0;
        if (i < 9 * CPB) return b[(i - CPB) / CPB];
        return 1'b1;
    endfunction

    // Entered just after frame cycle 'first'; leaves just after the edge that
    // returns the transmitter to idle.
    task automatic check_frame(input logic [7:0] b, input int first, input string tag);
        int         bad;
        logic [7:0] got;
        bad = 0;
        got = 8'h00;
        for (int i = first; i < 10 * CPB; i++) begin
            if (tx !== exp_tx(b, i) || busy !== 1'b1) bad++;
            if (i >= CPB && i < 9 * CPB && (i % CPB) == CPB / 2) got[(i - CPB) / CPB] = tx;
            step();
        end
        check({tag, " byte"}, 32'(got), 32'(b));
        check({tag, " waveform"}, bad, 0);
        check({tag, " end busy"}, 32'(busy), 0);
        check({tag, " end tx"}, 32'(tx), 1);
    endtask

    task automatic check_quiet(input int cycles, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            step();
        end
        check(tag, bad, 0);
    endtask

    initial begin
        logic [7:0] b;

        bus.Out_Portin = 1'b0;
        bus.Busout     = 32'h0;
        Reset          = 1'b1;
        step();
        step();
        Reset = 1'b0;
        check("reset tx", 32'(tx), 1);
        check("reset busy", 32'(busy), 0);
        check("reset empty", 32'(fifo_empty), 1);
        check("reset full", 32'(fifo_full), 0);
        check("reset count", 32'(fifo_count), 0);
        check("reset overflow", 32'(overflow), 0);
        check("reset state", 32'(dbg_state), 0);

        // Single byte: upper bus bits must be ignored.
        push(32'h123456A5);
        step();
        bus.Out_Portin = 1'b0;
        check("t1 count after push", 32'(fifo_count), 1);
        check("t1 empty after push", 32'(fifo_empty), 0);
        check("t1 tx still idle", 32'(tx), 1);
        step();
        check("t1 start tx", 32'(tx), 0);
        check("t1 start busy", 32'(busy), 1);
        check("t1 count after pop", 32'(fifo_count), 0);
        check("t1 empty after pop", 32'(fifo_empty), 1);
        check_frame(8'hA5, 0, "t1");
        check("t1 count end", 32'(fifo_count), 0);
        check_quiet(5, "t1 idle after frame");

        // Three consecutive writes; the pop coincides with the second push.
        push(32'hFFFFFF01);
        step();
        check("t2 count p0", 32'(fifo_count), 1);
        push(32'h00000002);
        step();
        check("t2 count p1", 32'(fifo_count), 1);
        check("t2 start tx", 32'(tx), 0);
        push(32'h00000003);
        step();
        bus.Out_Portin = 1'b0;
        check("t2 count peak", 32'(fifo_count), 2);
        check_frame(8'h01, 1, "t2 f1");
        check("t2 count gap", 32'(fifo_count), 2);
        step();
        check("t2 gap then start", 32'(tx), 0);
        check("t2 count f2", 32'(fifo_count), 1);
        check_frame(8'h02, 0, "t2 f2");
        step();
        check("t2 f3 start", 32'(tx), 0);
        check_frame(8'h03, 0, "t2 f3");
        check("t2 count end", 32'(fifo_count), 0);
        check("t2 empty end", 32'(fifo_empty), 1);
        check_quiet(5, "t2 idle after frames");

        // Ten writes: one to the shifter, eight queued, the last dropped.
        for (int k = 0; k < 10; k++) begin
            push(32'hABCD0010 + 32'(k));
            step();
        end
        bus.Out_Portin = 1'b0;
        check("t3 count full", 32'(fifo_count), 8);
        check("t3 full flag", 32'(fifo_full), 1);
        check("t3 overflow", 32'(overflow), 1);
        check_frame(8'h10, 8, "t3 f10");
        for (int k = 1; k < 9; k++) begin
            step();
            check("t3 frame start", 32'(tx), 0);
            check_frame(8'h10 + 8'(k), 0, "t3 fk");
        end
        check("t3 count end", 32'(fifo_count), 0);
        check("t3 empty end", 32'(fifo_empty), 1);
        check_quiet(40, "t3 no tenth frame");
        check("t3 overflow sticky", 32'(overflow), 1);

        // Full queue with a push landing on the idle pop edge.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("t4 overflow cleared", 32'(overflow), 0);
        for (int k = 0; k < 9; k++) begin
            push(32'h00000020 + 32'(k));
            step();
        end
        bus.Out_Portin = 1'b0;
        check("t4 count full", 32'(fifo_count), 8);
        check("t4 full flag", 32'(fifo_full), 1);
        check("t4 no overflow yet", 32'(overflow), 0);
        check_frame(8'h20, 7, "t4 f20");
        check("t4 still full", 32'(fifo_count), 8);
        push(32'h000000EE);
        step();
        bus.Out_Portin = 1'b0;
        check("t4 count 8 to 7", 32'(fifo_count), 7);
        check("t4 full cleared", 32'(fifo_full), 0);
        check("t4 overflow", 32'(overflow), 1);
        check("t4 start tx", 32'(tx), 0);
        check_frame(8'h21, 0, "t4 f21");
        step();
        check("t4 f22 start", 32'(tx), 0);

        // Reset in the middle of data bit 3 of 0x22.
        for (int i = 0; i < 70; i++) step();
        check("t5 in data state", 32'(dbg_state), 2);
        check("t5 bit3 level", 32'(tx), 0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("t5 tx", 32'(tx), 1);
        check("t5 busy", 32'(busy), 0);
        check("t5 count", 32'(fifo_count), 0);
        check("t5 overflow", 32'(overflow), 0);
        check("t5 empty", 32'(fifo_empty), 1);
        check("t5 state", 32'(dbg_state), 0);
        check_quiet(200, "t5 no further frames");

        // Twenty single bytes walk the pointers around the queue more than twice.
        for (int k = 0; k < 20; k++) begin
            b = 8'(k * 37 + 3);
            push({24'(k * 5), b});
            step();
            bus.Out_Portin = 1'b0;
            check("t6 count after push", 32'(fifo_count), 1);
            step();
            check("t6 count after pop", 32'(fifo_count), 0);
            check("t6 start tx", 32'(tx), 0);
            check_frame(b, 0, "t6");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
